// File: rtl/dec_rr_arbiter_if.sv
// Request/decoder-drive bundle between eight requesters and the select-decoder arbiter.
interface dec_rr_arbiter_if;
  logic [7:0] req;
  logic       sel4, sel2, sel1;
  logic       nen1, nen2;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout_err;

  modport master (output req,
                  input  sel4, sel2, sel1, nen1, nen2, gnt_valid, gnt_id, timeout_err);
  modport slave  (input  req,
                  output sel4, sel2, sel1, nen1, nen2, gnt_valid, gnt_id, timeout_err);
endinterface

// File: rtl/dec_rr_arbiter.sv
// Round-robin owner selection and enable sequencing for a 3-to-8 select decoder:
// address setup before enable, a dead gap between owners, optional grant timeout.
module dec_rr_arbiter #(
  parameter int TIMEOUT     = 256,
  parameter int DEAD_CYCLES = 1
) (
  input logic            clk,
  input logic            rst_n,
  dec_rr_arbiter_if.slave bus
);
  localparam int NUM_LANES = 8;
  localparam int IDW = $clog2(NUM_LANES);
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DW  = (DEAD_CYCLES > 2) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [DW-1:0] DLIM = DW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, DEAD} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] id, id_n, last, last_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [DW-1:0]  dcnt, dcnt_n;
  logic           nen, nen_n, gv, gv_n, terr, terr_n;

  // Rotate the request vector so bit 0 is the lane just after the last owner.
  logic [2*NUM_LANES-1:0] dbl;
  logic [NUM_LANES-1:0]   rot;
  logic [IDW:0]           start;
  logic [IDW-1:0]         pick_off, pick;

  always_comb begin
    dbl      = {bus.req, bus.req};
    start    = {1'b0, last} + (IDW+1)'(1);
    rot      = dbl[start +: NUM_LANES];
    pick_off = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (rot[i]) pick_off = IDW'(i);
    pick     = last + IDW'(1) + pick_off;
  end

  always_comb begin
    state_n = state;
    id_n    = id;
    last_n  = last;
    cnt_n   = cnt;
    dcnt_n  = dcnt;
    nen_n   = nen;
    gv_n    = gv;
    terr_n  = 1'b0;
    case (state)
      IDLE: if (|bus.req) begin
        id_n    = pick;
        state_n = SETUP;
      end
      SETUP: if (bus.req[id]) begin
        nen_n   = 1'b0;
        gv_n    = 1'b1;
        cnt_n   = '0;
        state_n = GRANT;
      end else begin
        last_n  = id;
        dcnt_n  = '0;
        state_n = DEAD;
      end
      GRANT: if (!bus.req[id] || (TIMEOUT != 0 && cnt == TLIM)) begin
        // Still requesting here means the exit was forced by the timeout.
        nen_n   = 1'b1;
        gv_n    = 1'b0;
        last_n  = id;
        dcnt_n  = '0;
        terr_n  = bus.req[id];
        state_n = DEAD;
      end else begin
        cnt_n   = cnt + CW'(1);
      end
      DEAD: if (dcnt == DLIM) state_n = IDLE;
            else              dcnt_n  = dcnt + DW'(1);
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      id    <= '0;
      last  <= '1;
      cnt   <= '0;
      dcnt  <= '0;
      nen   <= 1'b1;
      gv    <= 1'b0;
      terr  <= 1'b0;
    end else begin
      state <= state_n;
      id    <= id_n;
      last  <= last_n;
      cnt   <= cnt_n;
      dcnt  <= dcnt_n;
      nen   <= nen_n;
      gv    <= gv_n;
      terr  <= terr_n;
    end
  end

  assign bus.sel4        = id[2];
  assign bus.sel2        = id[1];
  assign bus.sel1        = id[0];
  assign bus.gnt_id      = id;
  assign bus.nen1        = nen;
  assign bus.nen2        = nen;
  assign bus.gnt_valid   = gv;
  assign bus.timeout_err = terr;
endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Scoreboard bench for dec_rr_arbiter: a transaction-level round-robin model queues
// expected grants; a negedge monitor checks each grant and the decoder invariants.
module tb_dec_rr_arbiter;
  localparam int TO = 4;
  localparam int DC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_rr_arbiter_if bus();
  dec_rr_arbiter #(.TIMEOUT(TO), .DEAD_CYCLES(DC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {int id; int len; bit to;} exp_t;
  exp_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_last = 7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // First requester at or after last+1, wrapping 7 -> 0.
  function automatic int rr_pick(input logic [7:0] m, input int last);
    for (int k = 1; k <= 8; k++)
      if (m[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction

  // Monitor: pops one expectation per rising gnt_valid, checks length at the fall.
  initial begin : mon
    bit         pgv, have, seen;
    logic [2:0] psel;
    int         glen, lowrun;
    exp_t       cur;
    pgv = 0; have = 0; seen = 0; psel = '0; glen = 0; lowrun = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pgv = 0; have = 0; seen = 0; glen = 0; lowrun = 0;
        continue;
      end
      check("nen1_eq_nen2", bus.nen1, bus.nen2);
      check("gv_eq_not_nen", bus.gnt_valid, !bus.nen1);
      check("id_eq_sel", bus.gnt_id, {bus.sel4, bus.sel2, bus.sel1});
      if (bus.gnt_valid && !pgv) begin
        if (seen) check("dead_gap", lowrun >= DC + 2, 1);
        if (expq.size() == 0) begin
          n_chk++; n_fail++; have = 0;
          $display("FAIL unexpected_grant: got id %0d expected no grant", bus.gnt_id);
        end else begin
          cur = expq.pop_front(); have = 1;
          check("grant_id", bus.gnt_id, cur.id);
        end
        glen = 1;
      end else if (bus.gnt_valid) begin
        check("sel_stable", bus.gnt_id, psel);
        glen++;
      end
      if (!bus.gnt_valid && pgv) begin
        check("dead_sel_hold", bus.gnt_id, psel);
        if (have) begin
          check("grant_len", glen, cur.len);
          check("timeout_err", bus.timeout_err, cur.to);
        end
        seen = 1; have = 0; lowrun = 1;
      end else begin
        check("timeout_err_quiet", bus.timeout_err, 0);
        if (!bus.gnt_valid) lowrun++;
      end
      pgv = bus.gnt_valid; psel = bus.gnt_id;
    end
  end

  // One ownership: present mask, owner holds for h enabled cycles (or until revoked).
  task automatic do_txn(input logic [7:0] mask, input int h);
    exp_t e;
    int   w, t, c;
    w = rr_pick(mask, model_last);
    e.id = w; e.to = (TO != 0) && (h > TO); e.len = e.to ? TO : h;
    expq.push_back(e);
    bus.req = mask;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.gnt_valid && t < 40);
    if (!bus.gnt_valid) begin
      n_chk++; n_fail++;
      $display("FAIL grant_wait: got no grant expected id %0d", w);
      void'(expq.pop_back());
      bus.req = '0;
      return;
    end
    c = 1;
    forever begin
      if (c == h) begin bus.req[w] = 1'b0; @(negedge clk); break; end
      @(negedge clk);
      if (!bus.gnt_valid) break;
      c++;
    end
    model_last = w;
  endtask

  initial begin : stim
    exp_t e;
    int   t;
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("rst_nen1", bus.nen1, 1);
    check("rst_nen2", bus.nen2, 1);
    check("rst_gv", bus.gnt_valid, 0);
    check("rst_id", bus.gnt_id, 0);
    check("rst_terr", bus.timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: sel after the sampling edge, enable one edge later, release next edge.
    e.id = 1; e.len = 2; e.to = 0; expq.push_back(e);
    bus.req = 8'h02;
    @(negedge clk);
    check("lat_sel", bus.gnt_id, 1);
    check("lat_setup_nen", bus.nen1, 1);
    @(negedge clk);
    check("lat_grant_nen", bus.nen1, 0);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    check("lat_release_nen", bus.nen1, 1);
    model_last = 1;
    repeat (3) @(negedge clk);

    // Full contention rotates through every requester.
    repeat (9) do_txn(8'hFF, 3);

    // Wrap-around priority and sel hold while idle.
    do_txn(8'h20, 2);
    do_txn(8'h21, 2);
    do_txn(8'h20, 2);
    do_txn(8'h60, 2);
    bus.req = '0;
    repeat (4) @(negedge clk);
    check("idle_sel_hold", bus.gnt_id, model_last);

    // Timeout then re-grant of the sole requester.
    do_txn(8'h08, 6);
    do_txn(8'h08, 2);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Request withdrawn during SETUP: no enable, pointer still advances.
    bus.req = 8'h04;
    @(negedge clk);
    bus.req = '0;
    repeat (6) @(negedge clk);
    model_last = 2;
    do_txn(8'h05, 2);

    // Reset in the middle of a grant.
    e.id = rr_pick(8'h40, model_last); e.len = 0; e.to = 0; expq.push_back(e);
    bus.req = 8'h40;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.gnt_valid && t < 40);
    check("pre_rst_grant", bus.gnt_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check("midrst_nen", bus.nen1, 1);
    check("midrst_id", bus.gnt_id, 0);
    check("midrst_gv", bus.gnt_valid, 0);
    expq.delete();
    rst_n = 1'b1;
    model_last = 7;
    @(negedge clk);
    do_txn(8'h48, 2);

    // Randomized ownerships, some long enough to time out.
    repeat (40) do_txn(8'($urandom_range(1, 255)), $urandom_range(1, 6));
    bus.req = '0;
    repeat (6) @(negedge clk);
    check("queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
